// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared helpers for the dff_pipe retiming pipe
package dff_pkg;

    // Bits needed to hold a count from 0 to depth inclusive.
    function automatic int cnt_width(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth + 1) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one valid+data register pair of the pipe
module dff_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            if (flush) begin
                v <= 1'b0;
            end else if (load) begin
                v <= 1'b1;
            end else if (drain) begin
                v <= 1'b0;
            end
            // Data is left stale when valid drops; only reset zeroes it.
            if (load && !flush) begin
                d <= load_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - DEPTH-stage valid/ready register pipe with flush and occupancy count
module dff_pipe
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            din,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            dout,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_xfer  = out_valid & out_ready;
    assign dout      = d[DEPTH-1];

    // Ready ripples combinationally from the consumer back to the producer.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = out_xfer;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    assign in_ready = ~rst & ~flush & (~v[0] | adv[0]);
    assign in_xfer  = in_valid & in_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             stage_load;
        logic [WIDTH-1:0] stage_data;
        if (g == 0) begin : g_head
            assign stage_load = in_xfer;
            assign stage_data = din;
        end else begin : g_body
            assign stage_load = adv[g-1];
            assign stage_data = d[g-1];
        end
        dff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .load      (stage_load),
            .load_data (stage_data),
            .drain     (adv[g]),
            .v         (v[g]),
            .d         (d[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4)
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] din;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] dout;
    logic             out_ready;
    logic             flush;
    logic [2:0]       count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q [$];

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", dout);
            end else begin
                chk("scoreboard_dout", dout, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] data, output bit acc);
        in_valid = 1'b1;
        din      = data;
        @(negedge clk);
        acc = in_ready;
        if (acc) exp_q.push_back(data);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_wait(input logic [WIDTH-1:0] data, input string name);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            send(data, acc);
        end
        chk(name, acc, 1);
    endtask

    task automatic wait_empty(input string name);
        for (int n = 0; n < 50 && count != 0; n++) begin
            tick();
        end
        chk(name, count, 0);
        chk({name, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_dout", dout, 0);
        chk("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        tick();

        // Streaming with consumer always ready
        out_ready = 1'b1;
        send(8'h11, acc); chk("stream_acc0", acc, 1);
        send(8'h22, acc); chk("stream_acc1", acc, 1);
        send(8'h33, acc); chk("stream_acc2", acc, 1);
        @(negedge clk);
        chk("stream_count_peak", count, 3);
        chk("stream_not_yet_valid", out_valid, 0);
        tick();
        @(negedge clk);
        chk("stream_latency_valid", out_valid, 1);
        chk("stream_first_word", dout, 8'h11);
        tick();
        wait_empty("stream_drain");

        // Backpressure fill
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + WIDTH'(i), acc);
            chk("bp_fill_acc", acc, 1);
        end
        @(negedge clk);
        chk("bp_full_count", count, 4);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_dout", dout, 8'hA0);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            din      = 8'hA4;
            @(negedge clk);
            chk("bp_stall_in_ready", in_ready, 0);
            chk("bp_stall_dout", dout, 8'hA0);
            chk("bp_stall_out_valid", out_valid, 1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_wait(8'hA4, "bp_accept_a4");
        send_wait(8'hA5, "bp_accept_a5");
        wait_empty("bp_drain");

        // Full pass-through
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'hB0 + WIDTH'(i), acc);
            chk("pt_fill_acc", acc, 1);
        end
        chk("pt_full_count", count, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(8'hB4 + WIDTH'(i), acc);
            chk("pt_acc", acc, 1);
            chk("pt_count_steady", count, 4);
        end
        wait_empty("pt_drain");

        // Flush with a competing input word
        out_ready = 1'b0;
        send(8'hC0, acc);
        send(8'hC1, acc);
        send(8'hC2, acc);
        chk("flush_pre_count", count, 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        din       = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_count", count, 0);
        chk("flush_out_valid_after", out_valid, 0);
        repeat (5) tick();
        chk("flush_stays_empty", count, 0);

        // Bubble collapse
        out_ready = 1'b0;
        send(8'h01, acc);
        tick();
        tick();
        send(8'h02, acc);
        chk("bubble_count", count, 2);
        repeat (3) tick();
        @(negedge clk);
        chk("bubble_count_settled", count, 2);
        chk("bubble_head", dout, 8'h01);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bubble_out0_valid", out_valid, 1);
        chk("bubble_out0", dout, 8'h01);
        tick();
        @(negedge clk);
        chk("bubble_out1_valid", out_valid, 1);
        chk("bubble_out1", dout, 8'h02);
        tick();
        @(negedge clk);
        chk("bubble_done", out_valid, 0);
        tick();
        chk("bubble_queue", exp_q.size(), 0);

        // Asynchronous reset with words inside
        out_ready = 1'b0;
        send(8'h5A, acc);
        send(8'h5B, acc);
        repeat (4) tick();
        @(negedge clk);
        chk("rst_mid_pre_count", count, 2);
        chk("rst_mid_pre_dout", dout, 8'h5A);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_dout", dout, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        exp_q.delete();
        #5;
        rst = 1'b0;
        #1;
        chk("rst_mid_release_in_ready", in_ready, 1);
        tick();
        chk("rst_mid_release_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
